// File: rtl/axi4_lite_write_path_pkg.sv
// Shared AXI4-lite definitions for the read and write paths:
// bus widths, response codes and FSM state encodings.
package axi4_lite_write_path_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        M_IDLE,
        M_SEND,
        M_RESP
    } master_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_RESP
    } slave_state_t;

    function automatic logic addr_aligned(input logic [ADDR_W-1:0] a);
        return a[2:0] == 3'b000;
    endfunction

endpackage

// File: rtl/axi4_lite_write_master.sv
// Write master: turns a host request pulse into AW/W beats,
// waits for the B response and reports it with a finish pulse.
module axi4_lite_write_master
    import axi4_lite_write_path_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic [STRB_W-1:0] strb,
    output logic              finish,
    output logic [1:0]        resp,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [ADDR_W-1:0] aw_addr,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic [STRB_W-1:0] w_strb,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_resp
);

    master_state_t state;
    logic          aw_done;
    logic          w_done;

    // A channel counts as done once its beat has been accepted.
    assign aw_done = !aw_valid || aw_ready;
    assign w_done  = !w_valid || w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= M_IDLE;
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
            b_ready  <= 1'b0;
            finish   <= 1'b0;
            resp     <= RESP_OKAY;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
        end else begin
            finish <= 1'b0;
            unique case (state)
                M_IDLE: begin
                    if (req) begin
                        aw_addr  <= addr;
                        w_data   <= data;
                        w_strb   <= strb;
                        aw_valid <= 1'b1;
                        w_valid  <= 1'b1;
                        state    <= M_SEND;
                    end
                end
                M_SEND: begin
                    if (aw_valid && aw_ready) aw_valid <= 1'b0;
                    if (w_valid && w_ready) w_valid <= 1'b0;
                    if (aw_done && w_done) begin
                        b_ready <= 1'b1;
                        state   <= M_RESP;
                    end
                end
                M_RESP: begin
                    if (b_valid) begin
                        resp    <= b_resp;
                        finish  <= 1'b1;
                        b_ready <= 1'b0;
                        state   <= M_IDLE;
                    end
                end
                default: state <= M_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi4_lite_write_slave.sv
// Write slave: latches AW/W beats, drives the RAM write port
// and returns OKAY, or SLVERR for a misaligned address.
module axi4_lite_write_slave
    import axi4_lite_write_path_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic [STRB_W-1:0] w_strb,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [1:0]        b_resp,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic [STRB_W-1:0] ram_mask,
    input  logic              ram_done
);

    slave_state_t      state;
    logic              aw_got;
    logic              w_got;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [STRB_W-1:0] strb_q;

    logic              aw_hs;
    logic              w_hs;
    logic              both;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;
    logic [STRB_W-1:0] strb_n;

    assign aw_hs  = aw_valid && aw_ready;
    assign w_hs   = w_valid && w_ready;
    assign both   = (aw_got || aw_hs) && (w_got || w_hs);
    // Beats arriving this cycle bypass the holding registers.
    assign addr_n = aw_hs ? aw_addr : addr_q;
    assign data_n = w_hs ? w_data : data_q;
    assign strb_n = w_hs ? w_strb : strb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            aw_ready  <= 1'b1;
            w_ready   <= 1'b1;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            b_valid   <= 1'b0;
            b_resp    <= RESP_OKAY;
            ram_write <= 1'b0;
            ram_addr  <= '0;
            ram_data  <= '0;
            ram_mask  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (aw_hs) begin
                        addr_q   <= aw_addr;
                        aw_got   <= 1'b1;
                        aw_ready <= 1'b0;
                    end
                    if (w_hs) begin
                        data_q  <= w_data;
                        strb_q  <= w_strb;
                        w_got   <= 1'b1;
                        w_ready <= 1'b0;
                    end
                    if (both) begin
                        aw_got <= 1'b0;
                        w_got  <= 1'b0;
                        if (!addr_aligned(addr_n)) begin
                            b_resp  <= RESP_SLVERR;
                            b_valid <= 1'b1;
                            state   <= S_RESP;
                        end else if (strb_n == '0) begin
                            b_resp  <= RESP_OKAY;
                            b_valid <= 1'b1;
                            state   <= S_RESP;
                        end else begin
                            ram_write <= 1'b1;
                            ram_addr  <= addr_n;
                            ram_data  <= data_n;
                            ram_mask  <= strb_n;
                            state     <= S_MEM;
                        end
                    end
                end
                S_MEM: begin
                    if (ram_done) begin
                        ram_write <= 1'b0;
                        b_resp    <= RESP_OKAY;
                        b_valid   <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (b_ready) begin
                        b_valid  <= 1'b0;
                        aw_ready <= 1'b1;
                        w_ready  <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi4_lite_write_path.sv
// AXI4-lite write path: host request -> master -> AW/W/B -> slave
// -> RAM write port. One transaction in flight at most.
module axi4_lite_write_path
    import axi4_lite_write_path_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [DATA_W-1:0] W_Data,
    input  logic [STRB_W-1:0] W_Strb,
    input  logic              W_Request,
    output logic              W_Finish,
    output logic [1:0]        W_Resp,
    output logic              Write_SIGNAL,
    output logic [ADDR_W-1:0] Write_ADDRESS,
    output logic [DATA_W-1:0] Write_DATA,
    output logic [STRB_W-1:0] Write_MASK,
    input  logic              WRITE_DONE
);

    logic              aw_valid;
    logic              aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              b_valid;
    logic              b_ready;
    logic [1:0]        b_resp;

    axi4_lite_write_master u_master (
        .clk      (CLK),
        .rst_n    (RST_N),
        .req      (W_Request),
        .addr     (W_Addr),
        .data     (W_Data),
        .strb     (W_Strb),
        .finish   (W_Finish),
        .resp     (W_Resp),
        .aw_valid (aw_valid),
        .aw_ready (aw_ready),
        .aw_addr  (aw_addr),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_data   (w_data),
        .w_strb   (w_strb),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_resp   (b_resp)
    );

    axi4_lite_write_slave u_slave (
        .clk       (CLK),
        .rst_n     (RST_N),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .aw_addr   (aw_addr),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_strb    (w_strb),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_resp    (b_resp),
        .ram_write (Write_SIGNAL),
        .ram_addr  (Write_ADDRESS),
        .ram_data  (Write_DATA),
        .ram_mask  (Write_MASK),
        .ram_done  (WRITE_DONE)
    );

endmodule

// File: doc/axi4_lite_write_path.md
# axi4_lite_write_path

Write-direction counterpart of the AXI4-lite read path: turns a single-beat host write request into an AXI4-lite AW/W/B transaction and services it with a built-in slave that drives a simple RAM write port. It sits between the core's store path and data memory, beside the read path, and shares its RAM-side signalling style (strobe plus done). It has one outstanding transaction at most and does not queue requests.

## Interface
- Parameters: none. Address and data are both 64 bits; the strobe is 8 bits (one bit per byte).
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- W_Addr  in  64  host write byte address.
- W_Data  in  64  host write data.
- W_Strb  in  8  host byte-enable mask.
- W_Request  in  1  single-cycle request pulse. Sampled only while the master is idle.
- W_Finish  out  1  one-cycle pulse marking transaction end.
- W_Resp  out  2  response of the last transaction. Valid while W_Finish is high and held until the next W_Finish.
- Write_SIGNAL  out  1  RAM write strobe. Held high until WRITE_DONE.
- Write_ADDRESS  out  64  RAM write address.
- Write_DATA  out  64  RAM write data.
- Write_MASK  out  8  RAM byte mask.
- WRITE_DONE  in  1  RAM has committed the write. Sampled only while Write_SIGNAL is high.

## Operation
**Master FSM (M_IDLE, M_SEND, M_RESP)**
- M_IDLE: on W_Request, register W_Addr/W_Data/W_Strb, raise AW_VALID and W_VALID, and go to M_SEND.
- M_SEND: each VALID drops in the cycle after its own VALID&READY handshake. The two channels complete independently, in either order or together. Once both are done, go to M_RESP with B_READY=1.
- M_RESP: on B_VALID&B_READY, capture B_RESP and return to M_IDLE. W_Finish is high for exactly the following cycle and W_Resp is updated in that cycle.
- A W_Request in the W_Finish cycle is accepted, which allows back-to-back writes.

**Slave FSM (S_IDLE, S_MEM, S_RESP)**
- S_IDLE: AW_READY=1 and W_READY=1 until the respective beat is latched; each READY then drops.
- When both the address and data beats are latched:
  - if AW_ADDR[2:0]!=0, go directly to S_RESP with B_RESP=2'b10 (SLVERR). No RAM access is made.
  - if the strobe is 0, go directly to S_RESP with B_RESP=2'b00 (OKAY). No RAM access is made.
  - otherwise go to S_MEM.
- S_MEM: Write_SIGNAL=1, with Write_ADDRESS/DATA/MASK driven from the latched values. On WRITE_DONE, set B_RESP=OKAY and go to S_RESP.
- S_RESP: B_VALID=1 until B_READY, then return to S_IDLE.
- Write_ADDRESS/DATA/MASK must not change while Write_SIGNAL is high.

## Timing
- Reset values:
  - W_Finish=0, W_Resp=0, Write_SIGNAL=0, Write_ADDRESS/DATA/MASK=0.
  - Internal AW_VALID, W_VALID, B_READY and B_VALID are 0.
  - Both FSMs are idle.
- Latency with WRITE_DONE tied high, where W_Request is high in cycle 0:
  - cycle 1: AW and W handshakes.
  - cycle 2: Write_SIGNAL is high.
  - cycle 3: B handshake.
  - cycle 4: W_Finish.
- Each cycle WRITE_DONE is held low adds one cycle.
- An error or zero-strobe write skips S_MEM, so W_Finish arrives in cycle 3.
- W_Request while the master is not in M_IDLE (other than in the W_Finish cycle) is ignored and produces no W_Finish.
- Reset asserted mid-transaction takes effect immediately:
  - all VALIDs and Write_SIGNAL drop asynchronously;
  - no W_Finish pulse is produced;
  - the in-flight write is abandoned. The RAM may or may not have committed it.
- VALID signals never depend combinationally on READY signals.

## Structure
- Shared package (shared with the read path):
  - response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the address and data width constants;
  - state encodings for both FSMs.
- Sub-modules: axi4_lite_write_master and axi4_lite_write_slave, instantiated by this top block. This mirrors the read path's master/slave split.
- Internal AW/W/B wires are declared in the top block only.

## Test plan
- Single write: W_Addr=0x8000_0010, W_Data=0xDEAD_BEEF_0123_4567, W_Strb=0xFF, WRITE_DONE tied 1 -> Write_SIGNAL high in cycle 2 with matching address/data/mask, W_Finish in cycle 4, W_Resp=00.
- RAM stall: WRITE_DONE held low for 5 cycles -> Write_SIGNAL and its payload are stable for 6 cycles, and W_Finish comes 5 cycles later than in the single-write case.
- Misaligned write: W_Addr=0x8000_0013 -> no Write_SIGNAL, W_Finish in cycle 3, W_Resp=10.
- Busy and back-to-back: a second W_Request in cycle 2 -> ignored, giving one RAM write only. A request in the W_Finish cycle -> a second full transaction with its own payload.
- Partial strobe: W_Strb=0x0F -> Write_MASK=0x0F. W_Strb=0x00 -> no RAM access, W_Resp=00.
- Reset mid-operation: assert RST_N=0 while in S_MEM -> Write_SIGNAL is 0 immediately, with no W_Finish. After release, a fresh write completes normally.
